sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 118 +++++++++++
 tb/tb_sync_fifo.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level, almost-full/empty thresholds and sticky ovf/udf.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads (default: registered rdata).
module sync_fifo #(
   parameter int DWIDTH    = 32,
   parameter int AWIDTH    = 5,
   parameter int AFULL_TH  = 28,
   parameter int AEMPTY_TH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DWIDTH-1:0] wdata,
   input  logic              fifowr,
   input  logic              fiford,
   output logic [DWIDTH-1:0] rdata,
   output logic              rvalid,
   output logic              wfull,
   output logic              rempty,
   output logic              walmost_full,
   output logic              ralmost_empty,
   output logic [AWIDTH:0]   level,
   output logic              ovf,
   output logic              udf
);

   localparam int DEPTH = 1 << AWIDTH;

   localparam logic [AWIDTH:0] DEPTH_L  = (AWIDTH+1)'(DEPTH);
   localparam logic [AWIDTH:0] AFULL_L  = (AWIDTH+1)'(AFULL_TH);
   localparam logic [AWIDTH:0] AEMPTY_L = (AWIDTH+1)'(AEMPTY_TH);

   logic [DWIDTH-1:0] mem [DEPTH];

   logic [AWIDTH:0]   wptr;
   logic [AWIDTH:0]   rptr;
   logic [AWIDTH-1:0] waddr;
   logic [AWIDTH-1:0] raddr;
   logic              wr_acc;
   logic              rd_acc;

   assign waddr = wptr[AWIDTH-1:0];
   assign raddr = rptr[AWIDTH-1:0];

   // Flags come from the registered level only, never from the requests.
   assign wfull         = (level == DEPTH_L);
   assign rempty        = (level == '0);
   assign walmost_full  = (level >= AFULL_L);
   assign ralmost_empty = (level <= AEMPTY_L);

   assign wr_acc = fifowr && !wfull;
   assign rd_acc = fiford && !rempty;

   // Storage is deliberately not reset; stale words are unreachable once
   // the pointers and level are cleared.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_acc) begin
            wptr <= wptr + 1'b1;
         end
         if (rd_acc) begin
            rptr <= rptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level <= '0;
      end else begin
         unique case ({wr_acc, rd_acc})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         if (fifowr && wfull) begin
            ovf <= 1'b1;
         end
         if (fiford && rempty) begin
            udf <= 1'b1;
         end
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is always on display; fiford just pops it.
   assign rdata  = mem[raddr];
   assign rvalid = !rempty;
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= rd_acc;
         if (rd_acc) begin
            rdata <= mem[raddr];
         end
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: vector table plus multi-cycle corner sequences.
// Works in both read modes (SYNC_FIFO_FWFT_EN defined or not).
module tb_sync_fifo;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] wdata;
   logic          fifowr;
   logic          fiford;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          wfull;
   logic          rempty;
   logic          walmost_full;
   logic          ralmost_empty;
   logic [AW:0]   level;
   logic          ovf;
   logic          udf;

   int n_chk  = 0;
   int n_fail = 0;

   sync_fifo #(
      .DWIDTH(DW), .AWIDTH(AW), .AFULL_TH(28), .AEMPTY_TH(4)
   ) dut (
      .clk(clk), .rst(rst), .wdata(wdata),
      .fifowr(fifowr), .fiford(fiford),
      .rdata(rdata), .rvalid(rvalid),
      .wfull(wfull), .rempty(rempty),
      .walmost_full(walmost_full), .ralmost_empty(ralmost_empty),
      .level(level), .ovf(ovf), .udf(udf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] wd;
      int          lvl;
      logic        rv;
      logic [31:0] rdat;
      logic        emp;
      logic        aemp;
      logic        ud;
   } vec_t;

   vec_t tbl [15];

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                  name, got, exp, $time);
      end
   endtask

   task automatic step(input logic wr, input logic rd,
                       input logic [31:0] wd);
      fifowr = wr;
      fiford = rd;
      wdata  = wd;
      @(posedge clk);
      #1;
      fifowr = 1'b0;
      fiford = 1'b0;
   endtask

   // Pops one word (optionally with a simultaneous write) and checks it.
   task automatic rd_word(input string name, input logic [31:0] exp,
                          input logic wr, input logic [31:0] wd);
`ifdef SYNC_FIFO_FWFT_EN
      check({name, " rvalid"}, 32'(rvalid), 32'd1);
      check({name, " rdata"}, rdata, exp);
      step(wr, 1'b1, wd);
`else
      step(wr, 1'b1, wd);
      check({name, " rvalid"}, 32'(rvalid), 32'd1);
      check({name, " rdata"}, rdata, exp);
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      fifowr = 1'b0;
      fiford = 1'b0;
      wdata  = '0;

      //                wr    rd    wd      lvl rv    rdat   emp   aemp  udf
      tbl[0]  = '{1'b1, 1'b0, 32'h11, 1, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 32'h22, 2, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 32'h33, 3, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 32'h44, 3, 1'b1, 32'h11, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 32'h00, 3, 1'b0, 32'h11, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 32'h00, 2, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 32'h00, 1, 1'b1, 32'h33, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 32'h00, 0, 1'b1, 32'h44, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 32'h00, 0, 1'b0, 32'h44, 1'b1, 1'b1, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 32'h55, 1, 1'b0, 32'h44, 1'b0, 1'b1, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 32'h66, 2, 1'b0, 32'h44, 1'b0, 1'b1, 1'b1};
      tbl[11] = '{1'b1, 1'b0, 32'h77, 3, 1'b0, 32'h44, 1'b0, 1'b1, 1'b1};
      tbl[12] = '{1'b1, 1'b0, 32'h88, 4, 1'b0, 32'h44, 1'b0, 1'b1, 1'b1};
      tbl[13] = '{1'b1, 1'b0, 32'h99, 5, 1'b0, 32'h44, 1'b0, 1'b0, 1'b1};
      tbl[14] = '{1'b0, 1'b1, 32'h00, 4, 1'b1, 32'h55, 1'b0, 1'b1, 1'b1};

      // Reset values before any clock edge
      #2;
      check("rst level", 32'(level), 32'd0);
      check("rst rempty", 32'(rempty), 32'd1);
      check("rst ralmost_empty", 32'(ralmost_empty), 32'd1);
      check("rst wfull", 32'(wfull), 32'd0);
      check("rst walmost_full", 32'(walmost_full), 32'd0);
      check("rst rvalid", 32'(rvalid), 32'd0);
      check("rst ovf", 32'(ovf), 32'd0);
      check("rst udf", 32'(udf), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
      check("rst rdata", rdata, 32'd0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Vector table
      for (int i = 0; i < 15; i++) begin
         step(tbl[i].wr, tbl[i].rd, tbl[i].wd);
         check($sformatf("vec%0d level", i), 32'(level), 32'(tbl[i].lvl));
         check($sformatf("vec%0d rempty", i), 32'(rempty), 32'(tbl[i].emp));
         check($sformatf("vec%0d ralmost_empty", i),
               32'(ralmost_empty), 32'(tbl[i].aemp));
         check($sformatf("vec%0d udf", i), 32'(udf), 32'(tbl[i].ud));
         check($sformatf("vec%0d ovf", i), 32'(ovf), 32'd0);
`ifdef SYNC_FIFO_FWFT_EN
         check($sformatf("vec%0d rvalid", i), 32'(rvalid), 32'(!tbl[i].emp));
`else
         check($sformatf("vec%0d rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
         check($sformatf("vec%0d rdata", i), rdata, tbl[i].rdat);
`endif
      end

      // Fill with 0xA0..0xBF
      do_reset();
      check("post-rst level", 32'(level), 32'd0);
      check("post-rst udf", 32'(udf), 32'd0);
      for (int i = 0; i < 32; i++) begin
         step(1'b1, 1'b0, 32'hA0 + 32'(i));
         check($sformatf("fill%0d level", i), 32'(level), 32'(i + 1));
         check($sformatf("fill%0d walmost_full", i),
               32'(walmost_full), 32'(i + 1 >= 28));
         check($sformatf("fill%0d wfull", i), 32'(wfull), 32'(i + 1 == 32));
         check($sformatf("fill%0d ovf", i), 32'(ovf), 32'd0);
      end

      // Write into a full FIFO is rejected and flagged
      step(1'b1, 1'b0, 32'hDEAD);
      check("ovf set", 32'(ovf), 32'd1);
      check("ovf level", 32'(level), 32'd32);
      step(1'b0, 1'b0, 32'h0);
      check("ovf sticky", 32'(ovf), 32'd1);

      // Drain; first pop also carries a write that must be rejected
      rd_word("drain0", 32'hA0, 1'b1, 32'hDEAD);
      check("full wr+rd level", 32'(level), 32'd31);
      for (int i = 1; i < 32; i++) begin
         rd_word($sformatf("drain%0d", i), 32'hA0 + 32'(i), 1'b0, 32'h0);
      end
      check("drain level", 32'(level), 32'd0);
      check("drain rempty", 32'(rempty), 32'd1);
      check("drain udf", 32'(udf), 32'd0);
      check("drain ovf sticky", 32'(ovf), 32'd1);

      // Pointer wrap: 3 rounds of 20 in, 20 out
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 32'h1000 * 32'(r + 1) + 32'(i));
         end
         check($sformatf("wrap%0d level", r), 32'(level), 32'd20);
         for (int i = 0; i < 20; i++) begin
            rd_word($sformatf("wrap%0d.%0d", r, i),
                    32'h1000 * 32'(r + 1) + 32'(i), 1'b0, 32'h0);
         end
         check($sformatf("wrap%0d empty", r), 32'(level), 32'd0);
      end

      // Empty with write+read together
      step(1'b1, 1'b1, 32'h55);
      check("udf set", 32'(udf), 32'd1);
      check("udf level", 32'(level), 32'd1);
      rd_word("udf word", 32'h55, 1'b0, 32'h0);
      check("udf after level", 32'(level), 32'd0);

      // Async reset mid-operation
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 32'h200 + 32'(i));
      end
      fifowr = 1'b1;
      fiford = 1'b1;
      wdata  = 32'h300;
      @(posedge clk);
      #1;
      check("pre-rst level", 32'(level), 32'd10);
      check("pre-rst rvalid", 32'(rvalid), 32'd1);
      check("pre-rst udf", 32'(udf), 32'd1);
      rst = 1'b1;
      #1;
      check("async level", 32'(level), 32'd0);
      check("async rempty", 32'(rempty), 32'd1);
      check("async rvalid", 32'(rvalid), 32'd0);
      check("async ovf", 32'(ovf), 32'd0);
      check("async udf", 32'(udf), 32'd0);
      fifowr = 1'b0;
      fiford = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // First edge after reset release accepts a write
      step(1'b1, 1'b0, 32'h77);
      check("post-rel level", 32'(level), 32'd1);
      rd_word("post-rel word", 32'h77, 1'b0, 32'h0);
      check("post-rel udf", 32'(udf), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
